icache_refill_ctrl: RTL and testbench

Miss-handling controller for the direct-mapped instruction cache. It accepts fetch requests and sequences the cache lookup. On a miss it issues a single-line burst read to main memory and assembles four 32-bit beats into a 128-bit line. It then writes the line into the cache and returns the requested word to fetch.

---
 rtl/icache_refill_ctrl.sv | 153 +++++++++++++++
 tb/tb_icache_refill_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: miss handler for the direct-mapped instruction cache.
// It looks the fetch address up in the cache. On a miss it reads the line from
// memory as a four-beat burst, writes the line into the cache, and then returns
// the requested word to fetch.
//
// Handshakes:
//   fetch: fetch_valid is sampled only in IDLE. Once a request is accepted,
//          stall stays high until the request is finished. fetch_ready is a
//          one-cycle completion pulse, and fetch_instr is valid with it.
//   mem:   mem_req and mem_addr hold steady until the first cycle in which
//          mem_gnt is high. After that, each mem_rvalid cycle delivers one beat,
//          word 0 first. Gaps between beats are allowed.
module icache_refill_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       fetch_valid,
    input  logic [ADDR_WIDTH-1:0]      fetch_pc,
    output logic                       fetch_ready,
    output logic [31:0]                fetch_instr,
    output logic                       stall,
    output logic [ADDR_WIDTH-1:0]      lookup_pc,
    input  logic                       cache_hit,
    input  logic [31:0]                cache_instr,
    output logic                       mem_req,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    input  logic                       mem_gnt,
    input  logic                       mem_rvalid,
    input  logic [31:0]                mem_rdata,
    output logic                       fill_valid,
    output logic [ADDR_WIDTH-1:0]      fill_pc,
    output logic [32*LINE_WORDS-1:0]   fill_line,
    output logic [2:0]                 dbg_state
);

    localparam int LB = 32 * LINE_WORDS;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_REQ    = 3'd2,
        S_BURST  = 3'd3,
        S_FILL   = 3'd4,
        S_REPLAY = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          beat_cnt;
    logic [LB-1:0]       line_q;
    logic [ADDR_WIDTH-1:0] pc_q;

    logic                  stall_d, fetch_ready_d, mem_req_d, fill_valid_d;
    logic [31:0]           fetch_instr_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d, fill_pc_d;
    logic [31:0]           replay_word;

    assign lookup_pc = pc_q;
    assign fill_line = line_q;
    assign dbg_state = state_q;
    assign replay_word = line_q[LB-1-32*int'(pc_q[3:2]) -: 32];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (fetch_valid) state_d = S_LOOKUP;
            S_LOOKUP: state_d = cache_hit ? S_IDLE : S_REQ;
            S_REQ:    if (mem_gnt) state_d = S_BURST;
            S_BURST:  if (mem_rvalid && beat_cnt == 2'd3) state_d = S_FILL;
            S_FILL:   state_d = S_REPLAY;
            S_REPLAY: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output logic: compute the next value of every registered output
    always_comb begin
        stall_d       = (state_d != S_IDLE);
        fetch_ready_d = 1'b0;
        fetch_instr_d = fetch_instr;
        mem_req_d     = (state_d == S_REQ);
        mem_addr_d    = mem_addr;
        fill_valid_d  = 1'b0;
        fill_pc_d     = fill_pc;
        case (state_q)
            S_LOOKUP: begin
                if (cache_hit) begin
                    fetch_ready_d = 1'b1;
                    fetch_instr_d = cache_instr;
                end else begin
                    mem_addr_d = {pc_q[ADDR_WIDTH-1:4], 4'b0000};
                end
            end
            S_FILL: begin
                fill_valid_d = 1'b1;
                fill_pc_d    = pc_q;
            end
            S_REPLAY: begin
                fetch_ready_d = 1'b1;
                fetch_instr_d = replay_word;
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall       <= 1'b0;
            fetch_ready <= 1'b0;
            fetch_instr <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            fill_valid  <= 1'b0;
            fill_pc     <= '0;
        end else begin
            stall       <= stall_d;
            fetch_ready <= fetch_ready_d;
            fetch_instr <= fetch_instr_d;
            mem_req     <= mem_req_d;
            mem_addr    <= mem_addr_d;
            fill_valid  <= fill_valid_d;
            fill_pc     <= fill_pc_d;
        end
    end

    // Latch the request address; beats are taken only while in BURST
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= '0;
            beat_cnt <= 2'd0;
            line_q   <= '0;
        end else begin
            if (state_q == S_IDLE && fetch_valid)
                pc_q <= fetch_pc;
            if (state_q == S_REQ && mem_gnt)
                beat_cnt <= 2'd0;
            if (state_q == S_BURST && mem_rvalid) begin
                line_q[LB-1-32*int'(beat_cnt) -: 32] <= mem_rdata;
                beat_cnt <= beat_cnt + 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl. It models the cache contents and main memory.
// Refill timing is predicted from the number of cycles the bench spends in
// each phase of the request.
module tb_icache_refill_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         fetch_valid;
    logic [31:0]  fetch_pc;
    logic         fetch_ready;
    logic [31:0]  fetch_instr;
    logic         stall;
    logic [31:0]  lookup_pc;
    logic         cache_hit;
    logic [31:0]  cache_instr;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_gnt;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;
    logic         fill_valid;
    logic [31:0]  fill_pc;
    logic [127:0] fill_line;
    logic [2:0]   dbg_state;

    int n_cmp = 0;
    int n_fail = 0;

    logic [127:0] cache_mem [int unsigned];

    typedef struct {
        int           lat;
        int           fills;
        int           fill_lat;
        logic [127:0] fline;
        logic [31:0]  fpc;
        logic [31:0]  instr;
        int           reqs;
        int           addr_changes;
        logic [31:0]  maddr;
        int           stall_drops;
        logic         first_stall;
        logic         ready_stall;
        int           burst_cyc;
        logic [31:0]  lpc;
    } obs_t;

    icache_refill_ctrl #(.ADDR_WIDTH(32), .LINE_WORDS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .fetch_ready(fetch_ready), .fetch_instr(fetch_instr), .stall(stall),
        .lookup_pc(lookup_pc), .cache_hit(cache_hit), .cache_instr(cache_instr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .fill_valid(fill_valid), .fill_pc(fill_pc), .fill_line(fill_line),
        .dbg_state(dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [127:0] line, input int idx);
        logic [127:0] sh;
        sh = line >> (32 * (3 - idx));
        return sh[31:0];
    endfunction

    function automatic logic [127:0] mem_line(input logic [31:0] addr);
        logic [127:0] l;
        logic [31:0]  base;
        l = '0;
        base = {addr[31:4], 4'b0000};
        for (int k = 0; k < 4; k++)
            l = (l << 32) | 128'((base + 32'(4 * k)) * 32'h9E37_79B1 ^ 32'h5A5A_0000);
        return l;
    endfunction

    // Drives one fetch from a negedge until fetch_ready is seen, or until a
    // cycle budget runs out. It acts as the cache and memory and records what it
    // observes. The lat value is the number of edges from acceptance to the edge
    // that raised fetch_ready.
    task automatic drive_fetch(input logic [31:0] pc, input logic [127:0] line,
                               input int gnt_wait, input int gap_mode,
                               input bit spurious, output obs_t o);
        int cyc, phase, beats, req_cnt;
        bit last_beat;
        o = '{default: 0};
        o.lat = -1;
        o.fill_lat = -1;
        phase = 0; beats = 0; req_cnt = 0; cyc = 0; last_beat = 0;
        fetch_valid = 1'b1;
        fetch_pc = pc;
        while (cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                fetch_valid = 1'b0;
                o.first_stall = stall;
                o.lpc = lookup_pc;
            end
            if (fill_valid) begin
                o.fills++;
                o.fline = fill_line;
                o.fpc = fill_pc;
                o.fill_lat = cyc - 1;
            end
            if (fetch_ready) begin
                o.lat = cyc - 1;
                o.instr = fetch_instr;
                o.ready_stall = stall;
                if (lookup_pc !== pc) o.lpc = lookup_pc;
                break;
            end
            if (!stall) o.stall_drops++;
            cache_hit = cache_mem.exists(lookup_pc >> 4);
            cache_instr = cache_hit ? word_of(cache_mem[lookup_pc >> 4], int'(lookup_pc[3:2])) : $urandom;
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata = $urandom;
            if (phase == 1) phase = 2;
            if (mem_req) begin
                if (req_cnt == 0) o.maddr = mem_addr;
                else if (mem_addr !== o.maddr) o.addr_changes++;
                req_cnt++;
                o.reqs++;
                if (phase == 0 && req_cnt > gnt_wait) begin
                    mem_gnt = 1'b1;
                    phase = 1;
                end
            end
            if (phase == 2) begin
                o.burst_cyc++;
                if ((gap_mode == 1 && last_beat) || (gap_mode == 2 && $urandom_range(0, 1) == 1)) begin
                    last_beat = 0;
                end else begin
                    mem_rvalid = 1'b1;
                    mem_rdata = word_of(line, beats);
                    beats++;
                    last_beat = 1;
                    if (beats == 4) phase = 3;
                end
            end else if (spurious) begin
                mem_rvalid = 1'b1;
                fetch_valid = 1'($urandom_range(0, 1));
                fetch_pc = $urandom;
            end
        end
        fetch_valid = 1'b0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        cache_hit = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({fetch_ready, stall, mem_req, fill_valid} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000", {fetch_ready, stall, mem_req, fill_valid});
        end
        n_cmp++;
        if ({fetch_instr, lookup_pc, mem_addr, fill_pc, fill_line} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got nonzero data buses, expected all zero");
        end
    endtask

    task automatic test_hit();
        obs_t o;
        cache_mem[32'h100 >> 4] = {32'h0101_0101, 32'hDEAD_BEEF, 32'h0303_0303, 32'h0404_0404};
        @(negedge clk);
        drive_fetch(32'h0000_0104, '0, 0, 0, 0, o);
        n_cmp++;
        if (o.lat !== 1) begin n_fail++; $display("FAIL hit_latency: got %0d expected 1", o.lat); end
        n_cmp++;
        if (o.instr !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL hit_instr: got %h expected deadbeef", o.instr); end
        n_cmp++;
        if (o.reqs !== 0 || o.fills !== 0) begin n_fail++; $display("FAIL hit_no_mem: got reqs=%0d fills=%0d expected 0/0", o.reqs, o.fills); end
    endtask

    task automatic test_cold_miss();
        obs_t o;
        logic [127:0] l;
        l = {32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        @(negedge clk);
        drive_fetch(32'h0000_0208, l, 0, 0, 0, o);
        n_cmp++;
        if (o.maddr !== 32'h0000_0200) begin n_fail++; $display("FAIL cold_mem_addr: got %h expected 00000200", o.maddr); end
        n_cmp++;
        if (o.fline !== l) begin n_fail++; $display("FAIL cold_fill_line: got %h expected %h", o.fline, l); end
        n_cmp++;
        if (o.instr !== 32'h3333_3333) begin n_fail++; $display("FAIL cold_instr: got %h expected 33333333", o.instr); end
        n_cmp++;
        if (o.lat !== 8) begin n_fail++; $display("FAIL cold_latency: got %0d expected 8", o.lat); end
        n_cmp++;
        if (o.fills !== 1 || o.fill_lat !== 7 || o.fpc !== 32'h0000_0208) begin
            n_fail++; $display("FAIL cold_fill: got fills=%0d at %0d pc=%h expected 1 at 7 pc=00000208", o.fills, o.fill_lat, o.fpc);
        end
        n_cmp++;
        if (o.stall_drops !== 0 || o.first_stall !== 1'b1 || o.ready_stall !== 1'b0) begin
            n_fail++; $display("FAIL cold_stall: got drops=%0d first=%b at_ready=%b expected 0/1/0", o.stall_drops, o.first_stall, o.ready_stall);
        end
        cache_mem[32'h208 >> 4] = l;
    endtask

    task automatic test_delayed_gnt();
        obs_t o;
        logic [127:0] l;
        l = {32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
        @(negedge clk);
        drive_fetch(32'h0000_050C, l, 3, 1, 0, o);
        n_cmp++;
        if (o.reqs !== 4 || o.addr_changes !== 0 || o.maddr !== 32'h0000_0500) begin
            n_fail++; $display("FAIL dly_req_hold: got reqs=%0d changes=%0d addr=%h expected 4/0/00000500", o.reqs, o.addr_changes, o.maddr);
        end
        n_cmp++;
        if (o.fline !== l || o.fills !== 1) begin n_fail++; $display("FAIL dly_fill: got %h fills=%0d expected %h fills=1", o.fline, o.fills, l); end
        n_cmp++;
        if (o.lat !== 1 + 4 + o.burst_cyc + 2) begin n_fail++; $display("FAIL dly_latency: got %0d expected %0d", o.lat, 7 + o.burst_cyc); end
        n_cmp++;
        if (o.instr !== word_of(l, 3)) begin n_fail++; $display("FAIL dly_instr: got %h expected %h", o.instr, word_of(l, 3)); end
        cache_mem[32'h50C >> 4] = l;
    endtask

    task automatic test_reset_mid_refill();
        obs_t o;
        logic [127:0] l;
        int bad;
        @(negedge clk); fetch_valid = 1'b1; fetch_pc = 32'h0000_0600; cache_hit = 1'b0;
        @(negedge clk); fetch_valid = 1'b0;
        @(negedge clk); mem_gnt = 1'b1;
        @(negedge clk); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_0000;
        @(negedge clk); mem_rdata = 32'hAAAA_0001;
        @(negedge clk); mem_rvalid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({fetch_ready, stall, mem_req, fill_valid, fetch_instr, lookup_pc, mem_addr, fill_pc, fill_line} !== '0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got stall=%b req=%b line=%h expected all zero", stall, mem_req, fill_line);
        end
        bad = 0;
        @(negedge clk); if (fill_valid || fetch_ready) bad++;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (fill_valid || fetch_ready || stall) bad++;
        end
        n_cmp++;
        if (bad !== 0) begin n_fail++; $display("FAIL rst_mid_quiet: got %0d active cycles expected 0", bad); end
        l = mem_line(32'h0000_0604);
        drive_fetch(32'h0000_0604, l, 0, 0, 0, o);
        n_cmp++;
        if (o.lat !== 8 || o.fline !== l || o.fills !== 1) begin
            n_fail++; $display("FAIL rst_mid_fresh: got lat=%0d line=%h fills=%0d expected 8 %h 1", o.lat, o.fline, o.fills, l);
        end
        cache_mem[32'h604 >> 4] = l;
    endtask

    task automatic test_spurious();
        obs_t o;
        logic [127:0] l;
        l = mem_line(32'h0000_070C);
        @(negedge clk);
        drive_fetch(32'h0000_070C, l, 2, 2, 1, o);
        n_cmp++;
        if (o.lpc !== 32'h0000_070C || o.fpc !== 32'h0000_070C || o.maddr !== 32'h0000_0700) begin
            n_fail++; $display("FAIL spur_addr: got lookup=%h fill=%h mem=%h expected 070c/070c/0700", o.lpc, o.fpc, o.maddr);
        end
        n_cmp++;
        if (o.fline !== l || o.instr !== word_of(l, 3)) begin
            n_fail++; $display("FAIL spur_line: got %h instr=%h expected %h instr=%h", o.fline, o.instr, l, word_of(l, 3));
        end
        n_cmp++;
        if (o.lat !== 1 + 3 + o.burst_cyc + 2) begin n_fail++; $display("FAIL spur_latency: got %0d expected %0d", o.lat, 6 + o.burst_cyc); end
        cache_mem[32'h70C >> 4] = l;
    endtask

    task automatic test_back_to_back();
        obs_t o1, o2;
        logic [127:0] l1, l2;
        l1 = mem_line(32'h0000_0300);
        l2 = mem_line(32'h0000_0400);
        @(negedge clk);
        drive_fetch(32'h0000_0300, l1, 0, 0, 0, o1);
        drive_fetch(32'h0000_0400, l2, 0, 0, 0, o2);
        n_cmp++;
        if (o1.fills !== 1 || o1.fpc !== 32'h0000_0300 || o2.fills !== 1 || o2.fpc !== 32'h0000_0400) begin
            n_fail++; $display("FAIL b2b_fills: got %0d@%h %0d@%h expected 1@0300 1@0400", o1.fills, o1.fpc, o2.fills, o2.fpc);
        end
        n_cmp++;
        if (o1.ready_stall !== 1'b0 || o2.first_stall !== 1'b1) begin
            n_fail++; $display("FAIL b2b_idle_gap: got idle_stall=%b next_stall=%b expected 0/1", o1.ready_stall, o2.first_stall);
        end
        n_cmp++;
        if (o2.lat !== 8 || o2.instr !== word_of(l2, 0)) begin
            n_fail++; $display("FAIL b2b_second: got lat=%0d instr=%h expected 8 %h", o2.lat, o2.instr, word_of(l2, 0));
        end
        cache_mem[32'h300 >> 4] = l1;
        cache_mem[32'h400 >> 4] = l2;
    endtask

    task automatic test_random();
        obs_t o;
        logic [31:0] pc;
        logic [127:0] l;
        int gw, gm, exp_lat;
        bit hit;
        for (int i = 0; i < 24; i++) begin
            pc = 32'h0000_1000 + ($urandom_range(0, 15) << 4) + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
            gw = $urandom_range(0, 3);
            gm = $urandom_range(0, 2);
            hit = cache_mem.exists(pc >> 4);
            l = hit ? cache_mem[pc >> 4] : mem_line(pc);
            @(negedge clk);
            drive_fetch(pc, l, gw, gm, 1'($urandom_range(0, 1)), o);
            exp_lat = hit ? 1 : 1 + (gw + 1) + o.burst_cyc + 2;
            n_cmp++;
            if (o.lat !== exp_lat || o.instr !== word_of(l, int'(pc[3:2])) || o.fills !== (hit ? 0 : 1)) begin
                n_fail++;
                $display("FAIL rand_%0d: pc=%h got lat=%0d instr=%h fills=%0d expected %0d %h %0d",
                         i, pc, o.lat, o.instr, o.fills, exp_lat, word_of(l, int'(pc[3:2])), hit ? 0 : 1);
            end
            if (!hit) cache_mem[pc >> 4] = l;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        fetch_valid = 1'b0; fetch_pc = '0;
        cache_hit = 1'b0; cache_instr = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_hit();
        test_cold_miss();
        test_delayed_gnt();
        test_reset_mid_refill();
        test_spurious();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
